// File: rtl/generic_func_pack.sv
// Shared elaboration-time helpers for parameter checking and pointer sizing.
package generic_func_pack;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Wrap-bit pointer width: RAM address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_sdp_ram.sv
// Distributed-RAM simple-dual-port memory: synchronous write, asynchronous read,
// contents cleared on asynchronous active-low reset.
module sdp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Combinational read; the consumer only ever sees it through m_data.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered output stage over sdp_ram.
// SYNC_FIFO_BYPASS_EN: a push into a fully empty FIFO loads m_data directly.
module sync_fifo
  import generic_func_pack::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [ptr_width(MEM_DEPTH)-1:0] count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned PW = ptr_width(MEM_DEPTH);

  if (!is_pow2(MEM_DEPTH) || MEM_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: MEM_DEPTH must be a power of 2 and at least 2");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic [PW-1:0]         ram_cnt;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  s_ready_q, s_ready_d;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  push, pop, load, bypass;

  assign push    = s_valid && s_ready_q;
  assign pop     = m_valid_q && m_ready;
  assign ram_cnt = wr_ptr_q - rd_ptr_q;
  // Output slot refills whenever it is free or being drained this cycle.
  assign load    = (ram_cnt != '0) && (!m_valid_q || pop);

`ifdef SYNC_FIFO_BYPASS_EN
  assign bypass = push && !m_valid_q && (ram_cnt == '0);
`else
  assign bypass = 1'b0;
`endif

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (s_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (ram_rd_data)
  );

  // Next-state for pointers, output stage and occupancy flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (bypass) begin
      // Skip the RAM slot just written: both pointers advance together.
      m_data_d  = s_data;
      m_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end else if (load) begin
      m_data_d  = ram_rd_data;
      m_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end else if (pop) begin
      m_valid_d = 1'b0;
    end

    count_d   = count_q + PW'(push) - PW'(pop);
    full_d    = (count_d == PW'(MEM_DEPTH));
    empty_d   = (count_d == '0);
    s_ready_d = !full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      s_ready_q <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule
